// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter.
// rw flags, port indices, FSM states.
package mem_arbiter_pkg;

   localparam logic [1:0] MEM_NOP   = 2'b00;
   localparam logic [1:0] MEM_READ  = 2'b01;
   localparam logic [1:0] MEM_WRITE = 2'b10;

   localparam logic PORT_IF   = 1'b0;
   localparam logic PORT_DATA = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_t;

   function automatic logic is_req(input logic [1:0] flag);
      return (flag == MEM_READ) || (flag == MEM_WRITE);
   endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Owner pick for the memory arbiter: data port wins,
// except when the fetch port has been starved too long.
module mem_arb_select
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       idle,
   input  logic       grant,
   input  logic [1:0] req_v,
   output logic       owner
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt;

   // Data port wins unless fetch is pending and has hit the limit.
   always_comb begin
      owner = PORT_IF;
      if (req_v[PORT_DATA] &&
          !(req_v[PORT_IF] && starve_cnt == LIMIT))
         owner = PORT_DATA;
   end

   // Count data grants that deferred a pending fetch.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (grant) begin
         if (owner == PORT_IF || !req_v[PORT_IF])
            starve_cnt <= '0;
         else if (starve_cnt != LIMIT)
            starve_cnt <= starve_cnt + 1'b1;
      end else if (idle && !req_v[PORT_IF]) begin
         starve_cnt <= '0;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of one memory-controller channel.
// Latches one request, drives the controller, routes completion.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MASK_W       = 4,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [3:0]          req_rw_flag_i,
   input  logic [2*ADDR_W-1:0] req_addr_i,
   input  logic [2*DATA_W-1:0] req_w_data_i,
   input  logic [2*MASK_W-1:0] req_w_mask_i,
   output logic [DATA_W-1:0]   req_r_data_o,
   output logic [1:0]          req_done_o,
   output logic [1:0]          req_busy_o,
   output logic [1:0]          mem_rw_flag_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_w_data_o,
   output logic [MASK_W-1:0]   mem_w_mask_o,
   input  logic [DATA_W-1:0]   mem_r_data_i,
   input  logic                mem_busy_i,
   input  logic                mem_done_i
);

   arb_state_t state, state_d;
   logic [1:0] req_v;
   logic       grant;
   logic       pick;
   logic       owner;
   logic [1:0] lat_rw;
   logic [1:0] pick_rw;

   assign req_v[0] = is_req(req_rw_flag_i[1:0]);
   assign req_v[1] = is_req(req_rw_flag_i[3:2]);
   assign pick_rw  = pick ? req_rw_flag_i[3:2]
                          : req_rw_flag_i[1:0];

   mem_arb_select #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_sel (
      .clk   (clk),
      .rst   (rst),
      .idle  (state == ST_IDLE),
      .grant (grant),
      .req_v (req_v),
      .owner (pick)
   );

   // Next-state logic; grant only from IDLE.
   always_comb begin
      state_d = state;
      grant   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (|req_v) begin
               grant   = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (mem_done_i)
               state_d = ST_DONE;
            else if (mem_busy_i)
               state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_done_i)
               state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State, request latch and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         owner         <= PORT_IF;
         lat_rw        <= MEM_NOP;
         mem_rw_flag_o <= MEM_NOP;
         mem_addr_o    <= '0;
         mem_w_data_o  <= '0;
         mem_w_mask_o  <= '0;
         req_r_data_o  <= '0;
         req_done_o    <= '0;
         req_busy_o    <= '0;
      end else begin
         state      <= state_d;
         req_done_o <= '0;
         unique case (state)
            ST_IDLE: begin
               if (grant) begin
                  owner         <= pick;
                  lat_rw        <= pick_rw;
                  mem_rw_flag_o <= pick_rw;
                  mem_addr_o    <= pick ?
                     req_addr_i[2*ADDR_W-1:ADDR_W] :
                     req_addr_i[ADDR_W-1:0];
                  mem_w_data_o  <= pick ?
                     req_w_data_i[2*DATA_W-1:DATA_W] :
                     req_w_data_i[DATA_W-1:0];
                  mem_w_mask_o  <= pick ?
                     req_w_mask_i[2*MASK_W-1:MASK_W] :
                     req_w_mask_i[MASK_W-1:0];
                  req_busy_o    <= pick ? 2'b10 : 2'b01;
               end
            end
            ST_ISSUE, ST_WAIT: begin
               if (mem_done_i || mem_busy_i)
                  mem_rw_flag_o <= MEM_NOP;
               if (mem_done_i) begin
                  req_done_o[owner] <= 1'b1;
                  if (lat_rw == MEM_READ)
                     req_r_data_o <= mem_r_data_i;
               end
            end
            ST_DONE: begin
               req_busy_o <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one memory-controller port between the CPU's instruction-fetch requester (port 0) and load/store requester (port 1). The block sits between the pipeline stages and one channel of `memory_controller`. It latches one request at a time, drives the controller's rw/addr/data/mask inputs, waits for completion, and returns the read data and a one-cycle done pulse to the owning requester. Data accesses have priority over fetches, and a starvation guard bounds how long a fetch can be deferred.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MASK_W`, 4, byte-write mask width
- `STARVE_LIMIT`, 4, maximum number of consecutive port-1 grants while port 0 is pending

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_rw_flag_i`  in  2*2  per-port request, port k at bits [2k+1:2k]; 00 none, 01 read, 10 write, 11 ignored
- `req_addr_i`  in  2*ADDR_W  per-port address
- `req_w_data_i`  in  2*DATA_W  per-port write data
- `req_w_mask_i`  in  2*MASK_W  per-port byte mask
- `req_r_data_o`  out  DATA_W  read data, valid while the matching `req_done_o` bit is high
- `req_done_o`  out  2  one-cycle completion pulse per port
- `req_busy_o`  out  2  port k has a latched, uncompleted transaction
- `mem_rw_flag_o`  out  2  to the controller; same encoding as the request flags
- `mem_addr_o`  out  ADDR_W  address to the controller
- `mem_w_data_o`  out  DATA_W  write data to the controller
- `mem_w_mask_o`  out  MASK_W  byte mask to the controller
- `mem_r_data_i`  in  DATA_W  controller read data, valid with `mem_done_i`
- `mem_busy_i`  in  1  controller has accepted the request and is working on it
- `mem_done_i`  in  1  controller completion pulse

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, DONE.
- **IDLE:** if either port requests 01 or 10, pick an owner, latch that port's rw/addr/data/mask plus the owner index, and go to ISSUE. Otherwise stay in IDLE.
- **Pick rule:** port 1 wins unless port 0 is pending and `starve_cnt == STARVE_LIMIT`. If only one port is requesting, that port wins.
- **Starvation counter `starve_cnt`:**
  - increments on a port-1 grant while port 0 is requesting;
  - clears on any port-0 grant, and in any IDLE cycle where port 0 is not requesting;
  - saturates at `STARVE_LIMIT`.
- **ISSUE:** drive `mem_rw_flag_o` with the latched flag; the mem_* outputs come from the latch.
  - If `mem_done_i` is high, go to DONE.
  - Otherwise, if `mem_busy_i` is high, go to WAIT.
  - Otherwise stay in ISSUE.
- **WAIT:** `mem_rw_flag_o` = 00; addr/data/mask remain held. On `mem_done_i`, go to DONE.
- **Read data capture:** on the `mem_done_i` cycle, `mem_r_data_i` is registered into `req_r_data_o`, but only for reads. For writes, `req_r_data_o` holds its previous value.
- **DONE:** `req_done_o[owner]` = 1 for exactly this cycle, then go to IDLE. Requests are not sampled in DONE.
- **Requester rule:** a requester holds its request stable until its done pulse. It may present a new request in the cycle after DONE; that request is evaluated in IDLE.
- **`req_busy_o[k]`:** 1 in ISSUE, WAIT and DONE when owner == k; 0 otherwise.
- **Dropped requests:** a request withdrawn before being granted is simply not granted. Withdrawal after the grant has no effect, because the latched copy is used.
- **Spurious controller signals:** `mem_done_i` or `mem_busy_i` seen in IDLE or DONE is ignored.

## Timing
- **Reset values (synchronous):** state IDLE, `starve_cnt` 0, owner 0, latched flag 00. Outputs: `mem_rw_flag_o` 00, `mem_addr_o` 0, `mem_w_data_o` 0, `mem_w_mask_o` 0, `req_r_data_o` 0, `req_done_o` 00, `req_busy_o` 00.
- **Reset mid-transaction:** the transaction is abandoned with no done pulse. The controller shares `rst`.
- **Issue latency:** a request visible in IDLE at cycle n produces `mem_rw_flag_o` ≠ 00 in cycle n+1.
- **Completion latency:** `mem_done_i` in cycle m produces `req_done_o` in cycle m+1.
- **Minimum transaction time:** 3 cycles from IDLE back to IDLE (IDLE, ISSUE with an immediate done, DONE).
- **Back-to-back throughput:** one transaction per (controller latency + 3) cycles.
- **Simultaneous requests in IDLE:** resolved in one cycle by the pick rule. Ties never leave both ports granted.
- **Output style:** all outputs are registered. There is no combinational path from any input to any output.

## Structure
- **Defines.vh** holds:
  - rw encodings `MEM_NOP` 2'b00, `MEM_READ` 2'b01, `MEM_WRITE` 2'b10;
  - port indices `PORT_IF` 0 and `PORT_DATA` 1;
  - FSM state encodings.
- **Sub-module `mem_arb_select`:** the pick rule plus `starve_cnt`. Inputs: the two request-valid bits and a grant strobe. Outputs: the owner index. The FSM, latch and response routing stay in `mem_arbiter`.

## Test plan
- **Single read.** Stimulus: port 0 read at 0x0000_0100; the controller raises busy 1 cycle after issue and done 4 cycles later with 0xDEAD_BEEF. Required: `mem_rw_flag_o` = 01 for one ISSUE cycle; `req_r_data_o` = 0xDEAD_BEEF together with `req_done_o` = 01, one cycle after `mem_done_i`; `req_busy_o[0]` falls after that cycle.
- **Simultaneous requests.** Stimulus: in the same cycle, port 1 writes 0x1234_5678 with mask 4'b0011 to 0x200 and port 0 reads 0x104. Required: the write is issued first with addr 0x200 and mask 0011; the read is issued only after the write's DONE.
- **Starvation.** Stimulus: port 1 requests continuously and port 0 holds a read, with `STARVE_LIMIT` = 4. Required: exactly 4 port-1 grants, then a port-0 grant, then the counter is back at 0.
- **Fast completion.** Stimulus: `mem_done_i` is asserted in the ISSUE cycle with `mem_busy_i` low. Required: WAIT is skipped and `req_done_o` is asserted next cycle.
- **Reset mid-operation.** Stimulus: `rst` asserted in WAIT, then done arrives afterwards. Required: all outputs at reset values next cycle; no `req_done_o` pulse.
- **Ignored encodings and spurious signals.** Stimulus: port 0 presents flag 11; `mem_done_i` pulses while in IDLE. Required: nothing is issued, no done pulse, and the state stays IDLE.
